// File: rtl/usr_pkg.sv
// Universal shift register shared constants: mode encoding and FSM states.
// Latency: n/a (declarations only). Backpressure: n/a.
// Imported by usr_step and usr_param_shift_reg.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_RSVD = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/usr_step.sv
// One-step next-value function of the shift register; LOAD is resolved by the caller.
// Latency: combinational. Backpressure: none.
// USR_ROTATE_EN enables ROR/ROL; without it those modes hold.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur_val,
    input  logic [2:0]       mode,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] next_val
);

    always_comb begin
        next_val = cur_val;
        case (mode)
            MODE_SHR: next_val = {serial_in_right, cur_val[WIDTH-1:1]};
            MODE_SHL: next_val = {cur_val[WIDTH-2:0], serial_in_left};
            MODE_ASR: next_val = {cur_val[WIDTH-1], cur_val[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            MODE_ROR: next_val = {cur_val[0], cur_val[WIDTH-1:1]};
            MODE_ROL: next_val = {cur_val[WIDTH-2:0], cur_val[WIDTH-1]};
`endif
            default:  next_val = cur_val;
        endcase
    end

endmodule

// File: rtl/usr_param_shift_reg.sv
// Parametrised universal shift register with free-running single steps and FSM-counted multi-step ops.
// Latency: single step 1 edge; counted op N+1 edges start-to-done. Rotate modes need USR_ROTATE_EN.
// Backpressure: start while busy is dropped, not queued; done is a one-cycle pulse.
module usr_param_shift_reg
    import usr_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out_left,
    output logic             serial_out_right,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;

    logic [2:0]       step_mode;
    logic [WIDTH-1:0] step_val;
    logic [CNT_W-1:0] eff_cnt;
    logic             once_mode;

    assign step_mode = (state_q == ST_RUN) ? mode_q : mode;
    assign eff_cnt   = (shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shamt;
    assign once_mode = (mode == MODE_LOAD) || (mode == MODE_HOLD) || (mode == MODE_RSVD);

    usr_step #(.WIDTH(WIDTH)) u_step (
        .cur_val         (data_q),
        .mode            (step_mode),
        .serial_in_left  (serial_in_left),
        .serial_in_right (serial_in_right),
        .next_val        (step_val)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        data_d  = data_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // LOAD/HOLD ignore the count: one action on the accept edge, then done
                    if (once_mode) begin
                        data_d = (mode == MODE_LOAD) ? data_in : data_q;
                        done_d = 1'b1;
                    end else if (eff_cnt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = eff_cnt;
                        mode_d  = mode;
                    end
                end else begin
                    data_d = (mode == MODE_LOAD) ? data_in : step_val;
                end
            end
            ST_RUN: begin
                data_d = step_val;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign data_out         = data_q;
    assign serial_out_left  = data_q[WIDTH-1];
    assign serial_out_right = data_q[0];
    assign busy             = (state_q == ST_RUN);
    assign done             = done_q;

endmodule

// File: tb/tb_usr_param_shift_reg.sv
// Directed bench for usr_param_shift_reg at WIDTH=8; expectations are hand-computed.
module tb_usr_param_shift_reg;
    import usr_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       mode;
    logic             start;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] data_in;
    logic             serial_in_left;
    logic             serial_in_right;
    logic [WIDTH-1:0] data_out;
    logic             serial_out_left;
    logic             serial_out_right;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    usr_param_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .start            (start),
        .shamt            (shamt),
        .data_in          (data_in),
        .serial_in_left   (serial_in_left),
        .serial_in_right  (serial_in_right),
        .data_out         (data_out),
        .serial_out_left  (serial_out_left),
        .serial_out_right (serial_out_right),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic do_load(input logic [WIDTH-1:0] v);
        mode = MODE_LOAD; data_in = v; start = 1'b0;
        @(posedge clk); #1;
        mode = MODE_HOLD;
    endtask

    // Issues one counted op and observes 12 post-edge samples starting with the accept edge.
    task automatic run_counted(input logic [2:0] m, input logic [CNT_W-1:0] n,
                               output int busy_cnt, output int done_cnt,
                               output int done_idx, output int overlap);
        mode = m; shamt = n; start = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_idx = -1; overlap = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin start = 1'b0; mode = MODE_HOLD; end
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_idx = i; end
            if (busy && done) overlap++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; mode = MODE_HOLD; start = 1'b0; shamt = '0; data_in = '0;
        serial_in_left = 1'b0; serial_in_right = 1'b0;
        #3;
        checks++; if ({data_out, serial_out_left, serial_out_right, busy, done} !== 12'h000) begin
            errors++; $display("FAIL reset_state got data=%h sol=%b sor=%b busy=%b done=%b want all 0",
                               data_out, serial_out_left, serial_out_right, busy, done);
        end
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic test_load();
        mode = MODE_LOAD; data_in = 8'hA5;
        @(posedge clk); #1;
        mode = MODE_HOLD;
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL load_data got %h want a5", data_out); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL load_flags got busy=%b done=%b want 0 0", busy, done); end
        checks++; if ({serial_out_left, serial_out_right} !== 2'b11) begin
            errors++; $display("FAIL load_serial_out got %b%b want 11", serial_out_left, serial_out_right);
        end
    endtask

    task automatic test_shr_counted();
        logic [WIDTH-1:0] exp_vals [3];
        exp_vals[0] = 8'hD2; exp_vals[1] = 8'hE9; exp_vals[2] = 8'hF4;
        serial_in_right = 1'b1; mode = MODE_SHR; shamt = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = MODE_HOLD;
        checks++; if ({busy, done, data_out} !== {2'b10, 8'hA5}) begin
            errors++; $display("FAIL shr_accept got busy=%b done=%b data=%h want 1 0 a5", busy, done, data_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (data_out !== exp_vals[i]) begin
                errors++; $display("FAIL shr_step%0d got %h want %h", i, data_out, exp_vals[i]);
            end
            checks++; if ({busy, done} !== ((i == 2) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL shr_flags%0d got busy=%b done=%b", i, busy, done);
            end
        end
        checks++; if ({serial_out_left, serial_out_right} !== 2'b10) begin
            errors++; $display("FAIL shr_serial_out got %b%b want 10", serial_out_left, serial_out_right);
        end
        @(posedge clk); #1;
        checks++; if ({busy, done, data_out} !== {2'b00, 8'hF4}) begin
            errors++; $display("FAIL shr_after got busy=%b done=%b data=%h want 0 0 f4", busy, done, data_out);
        end
        serial_in_right = 1'b0;
    endtask

    task automatic test_asr();
        int b, d, di, ov;
        do_load(8'h80);
        run_counted(MODE_ASR, 4'd2, b, d, di, ov);
        checks++; if (data_out !== 8'hE0) begin errors++; $display("FAIL asr_data got %h want e0", data_out); end
        checks++; if ({b, d, di, ov} !== {32'd2, 32'd1, 32'd2, 32'd0}) begin
            errors++; $display("FAIL asr_timing got busy=%0d done=%0d at=%0d overlap=%0d want 2 1 2 0", b, d, di, ov);
        end
    endtask

    task automatic test_rol();
        int b, d, di, ov;
        logic [WIDTH-1:0] exp_v;
`ifdef USR_ROTATE_EN
        exp_v = 8'h5A;
`else
        exp_v = 8'hA5;
`endif
        do_load(8'hA5);
        run_counted(MODE_ROL, 4'd4, b, d, di, ov);
        checks++; if (data_out !== exp_v) begin errors++; $display("FAIL rol_data got %h want %h", data_out, exp_v); end
        checks++; if ({b, d, di, ov} !== {32'd4, 32'd1, 32'd4, 32'd0}) begin
            errors++; $display("FAIL rol_timing got busy=%0d done=%0d at=%0d overlap=%0d want 4 1 4 0", b, d, di, ov);
        end
    endtask

    task automatic test_shl_clamp();
        int b, d, di, ov;
        do_load(8'hFF);
        serial_in_left = 1'b0;
        run_counted(MODE_SHL, 4'd12, b, d, di, ov);
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL shl_clamp_data got %h want 00", data_out); end
        checks++; if ({b, d, di, ov} !== {32'd8, 32'd1, 32'd8, 32'd0}) begin
            errors++; $display("FAIL shl_clamp_timing got busy=%0d done=%0d at=%0d overlap=%0d want 8 1 8 0", b, d, di, ov);
        end
    endtask

    task automatic test_zero_and_load_start();
        int b, d, di, ov;
        do_load(8'h3C);
        run_counted(MODE_SHR, 4'd0, b, d, di, ov);
        checks++; if ({data_out, b[7:0], d[7:0], di[7:0]} !== {8'h3C, 8'd0, 8'd1, 8'd0}) begin
            errors++; $display("FAIL zero_count got data=%h busy=%0d done=%0d at=%0d want 3c 0 1 0", data_out, b, d, di);
        end
        data_in = 8'hC3;
        run_counted(MODE_LOAD, 4'd5, b, d, di, ov);
        checks++; if ({data_out, b[7:0], d[7:0], di[7:0]} !== {8'hC3, 8'd0, 8'd1, 8'd0}) begin
            errors++; $display("FAIL load_start got data=%h busy=%0d done=%0d at=%0d want c3 0 1 0", data_out, b, d, di);
        end
    endtask

    task automatic test_back_to_back();
        do_load(8'h81);
        serial_in_left = 1'b1; serial_in_right = 1'b0;
        mode = MODE_SHR; shamt = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = MODE_HOLD;
        @(posedge clk); #1;
        checks++; if ({busy, done, data_out} !== {2'b01, 8'h40}) begin
            errors++; $display("FAIL b2b_first got busy=%b done=%b data=%h want 0 1 40", busy, done, data_out);
        end
        mode = MODE_SHL; shamt = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = MODE_HOLD;
        checks++; if ({busy, done, data_out} !== {2'b10, 8'h40}) begin
            errors++; $display("FAIL b2b_accept got busy=%b done=%b data=%h want 1 0 40", busy, done, data_out);
        end
        @(posedge clk); #1;
        checks++; if ({busy, done, data_out} !== {2'b01, 8'h81}) begin
            errors++; $display("FAIL b2b_second got busy=%b done=%b data=%h want 0 1 81", busy, done, data_out);
        end
        serial_in_left = 1'b0;
    endtask

    task automatic test_ignore_and_reset();
        int done_seen;
        do_load(8'h80);
        serial_in_right = 1'b0;
        mode = MODE_SHR; shamt = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = MODE_HOLD;
        @(posedge clk); #1;
        mode = MODE_LOAD; data_in = 8'hFF; shamt = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mode = MODE_HOLD;
        @(posedge clk); #1;
        checks++; if ({busy, done, data_out} !== {2'b10, 8'h10}) begin
            errors++; $display("FAIL ignore_start got busy=%b done=%b data=%h want 1 0 10", busy, done, data_out);
        end
        #2; reset = 1'b0; #1;
        checks++; if ({busy, done, data_out} !== {2'b00, 8'h00}) begin
            errors++; $display("FAIL async_reset got busy=%b done=%b data=%h want 0 0 00", busy, done, data_out);
        end
        @(negedge clk); @(negedge clk); reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy || data_out != 8'h00) done_seen++;
        end
        checks++; if (done_seen !== 0) begin
            errors++; $display("FAIL post_reset_quiet got %0d active samples want 0", done_seen);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shr_counted();
        test_asr();
        test_rol();
        test_shl_clamp();
        test_zero_and_load_start();
        test_back_to_back();
        test_ignore_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usr_param_shift_reg.md
# usr_param_shift_reg

Parametrised universal shift register. Keeps the single-step hold / shift-right / shift-left / parallel-load behaviour and adds rotate and arithmetic-shift modes. Adds a counted multi-bit shift sequenced by a small FSM, with a busy/done handshake. Sits on datapath and serial-link paths that previously used a fixed 4-bit universal shift register.

## Interface
- WIDTH, 8, register width in bits (≥2)
- CNT_W, $clog2(WIDTH+1), shift-count width (localparam, derived, not overridable)

Ports (clock and reset first):
- clk  in  1  rising-edge clock; the block's only clock
- reset  in  1  asynchronous, active-low reset
- mode  in  3  operation select (encoding under Operation)
- start  in  1  request a counted operation of `shamt` steps
- shamt  in  CNT_W  step count for a counted operation
- data_in  in  WIDTH  parallel load value
- serial_in_left  in  1  bit inserted at LSB on a left shift
- serial_in_right  in  1  bit inserted at MSB on a right shift
- data_out  out  WIDTH  register contents
- serial_out_left  out  1  data_out[WIDTH-1]
- serial_out_right  out  1  data_out[0]
- busy  out  1  counted operation in progress
- done  out  1  one-cycle pulse when a counted operation completes

## Operation
- Mode encoding:
  - 000 HOLD
  - 001 SHR: MSB ← serial_in_right
  - 010 SHL: LSB ← serial_in_left
  - 011 LOAD: data_in
  - 100 ROR
  - 101 ROL
  - 110 ASR: MSB replicated
  - 111 reserved; behaves as HOLD
- FSM states are IDLE and RUN.
- IDLE with start=0: the current mode is applied once per clock, i.e. free-running single-step behaviour.
- IDLE with start=1:
  - Latch mode and the effective count N = min(shamt, WIDTH).
  - If N>0, enter RUN. No data change on the accept edge.
  - If N=0, stay in IDLE, leave data unchanged, and pulse done next cycle.
  - LOAD or HOLD with start executes once on the accept edge, then pulses done. No RUN state is entered.
- RUN:
  - Apply the latched mode once per edge for N edges, decrementing the remaining count.
  - The live `mode`, `start`, `shamt` and `data_in` inputs are ignored.
  - serial_in_left and serial_in_right are sampled live on each step edge.
  - On the last step, return to IDLE and pulse done.
- A start asserted while busy is ignored. It is not queued.
- Reset asserted at any time, including mid-RUN:
  - data_out=0, busy=0, done=0, state IDLE, count 0.
  - The in-flight operation is discarded.

## Timing
- Reset values: data_out=0, serial_out_left=0, serial_out_right=0, busy=0, done=0.
- data_out is registered. Single-step results appear after the sampling edge.
- Start accepted at edge k with N>0:
  - Steps occur at edges k+1 … k+N.
  - busy=1 from edge k to edge k+N.
  - done=1 for exactly one cycle after edge k+N.
  - Start-to-done latency is N+1 edges.
- N=0, LOAD or HOLD with start: done=1 for one cycle after the accept edge; busy stays 0.
- done and busy are never high together.
- A new start is accepted on the edge ending the done cycle (back-to-back allowed).
- serial_out_* are combinational decodes of the data_out register.

## Configuration
- Macro `USR_ROTATE_EN`:
  - Defined: modes 100 (ROR) and 101 (ROL) rotate as specified.
  - Undefined: modes 100 and 101 decode as HOLD. Counted operations with them still run N cycles with busy/done but leave data unchanged.

## Structure
- Package `usr_pkg` holds the mode encoding constants (MODE_HOLD … MODE_ASR) and the FSM state constants.
- One sub-module, `usr_step`: combinational next-value function.
  - Inputs: WIDTH-parameterised value, mode, serial_in_left, serial_in_right.
  - Used by both the single-step path and RUN.
  - Contains the `USR_ROTATE_EN` guard.
- The top level holds the data register, the count register, the latched mode and the FSM.

## Test plan
All scenarios use WIDTH=8.
- LOAD 0xA5 with start=0 → data_out=0xA5 after one edge; busy and done stay 0.
- From 0xA5, start with SHR, shamt=3, serial_in_right=1 → busy for 3 cycles, data_out 0xD2, 0xE9, 0xF4, then done pulses once.
- From 0x80, start with ASR, shamt=2 → 0xE0.
- From 0xA5, start with ROL, shamt=4 → 0x5A with `USR_ROTATE_EN`; 0xA5 without it. Busy lasts 4 cycles in both builds.
- From 0xFF, start with SHL, shamt=12, serial_in_left=0 → clamped to 8 steps, data_out=0x00, busy for 8 cycles.
- Mid-RUN: a second start with a different mode is ignored. Then reset asserted mid-RUN → data_out=0 and busy=0 immediately (asynchronously), and no done pulse.
